// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Brief    : Hazard-unit bundle between the pipeline stages and hazard_ctrl.
// Revision : 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) ();
    logic [5*NUM_SRC-1:0] RsD;
    logic [5*NUM_SRC-1:0] RsE;
    logic [4:0]           RdE;
    logic [4:0]           RdM;
    logic [4:0]           RdW;
    logic                 RegWriteE;
    logic                 RegWriteM;
    logic                 RegWriteW;
    logic                 LoadE;
    logic                 McStartE;
    logic                 PCSrcE;
    logic [2*NUM_SRC-1:0] ForwardE;
    logic                 StallF;
    logic                 StallD;
    logic                 StallE;
    logic                 FlushD;
    logic                 FlushE;
    logic                 FlushM;
    logic                 McDoneE;
    logic [CNT_W-1:0]     LuStallCnt;
    logic [CNT_W-1:0]     FlushCnt;
    logic [CNT_W-1:0]     McStallCnt;

    modport master (
        output RsD, RsE, RdE, RdM, RdW, RegWriteE, RegWriteM, RegWriteW,
               LoadE, McStartE, PCSrcE,
        input  ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
               McDoneE, LuStallCnt, FlushCnt, McStallCnt
    );

    modport slave (
        input  RsD, RsE, RdE, RdM, RdW, RegWriteE, RegWriteM, RegWriteW,
               LoadE, McStartE, PCSrcE,
        output ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
               McDoneE, LuStallCnt, FlushCnt, McStallCnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Forwarding, load-use stall, branch flush and multicycle hold.
//            Define HAZARD_PERF_CNT_EN to build the saturating perf counters.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input  wire logic    CLK,
    input  wire logic    RESET,
    hazard_ctrl_if.slave hz
);
    localparam int C_CW = $clog2(MC_LAT);
    localparam logic [C_CW-1:0] C_LOAD = C_CW'(MC_LAT - 2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [C_CW-1:0]     r_cnt;
    logic                r_done;

    logic [2*NUM_SRC-1:0] w_fwd;
    logic [NUM_SRC-1:0]   w_match;
    logic                 w_lw_stall;
    logic                 w_mc_stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [4:0] w_rs_e;
        logic [4:0] w_rs_d;
        assign w_rs_e = hz.RsE[5*i +: 5];
        assign w_rs_d = hz.RsD[5*i +: 5];
        // Memory stage holds the younger result, so it is checked first.
        assign w_fwd[2*i +: 2] =
            (w_rs_e != 5'd0 && w_rs_e == hz.RdM && hz.RegWriteM) ? 2'b10 :
            (w_rs_e != 5'd0 && w_rs_e == hz.RdW && hz.RegWriteW) ? 2'b01 :
                                                                   2'b00;
        assign w_match[i] = (w_rs_d == hz.RdE);
    end

    assign w_lw_stall = hz.LoadE && hz.RegWriteE && (hz.RdE != 5'd0) && (|w_match);
    assign w_mc_stall = ((r_state == S_IDLE) && hz.McStartE) ||
                        ((r_state == S_BUSY) && (r_cnt != '0));

    assign hz.ForwardE = w_fwd;
    assign hz.StallF   = w_mc_stall || (!hz.PCSrcE && w_lw_stall);
    assign hz.StallD   = w_mc_stall || (!hz.PCSrcE && w_lw_stall);
    assign hz.StallE   = w_mc_stall;
    assign hz.FlushD   = !w_mc_stall && hz.PCSrcE;
    assign hz.FlushE   = !w_mc_stall && (hz.PCSrcE || w_lw_stall);
    assign hz.FlushM   = w_mc_stall;
    assign hz.McDoneE  = r_done;

    // McDoneE is registered: it is raised on the edge that lands the FSM in BUSY with cnt==0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hz.McStartE) begin
                        r_state <= S_BUSY;
                        r_cnt   <= C_LOAD;
                        r_done  <= (MC_LAT == 2);
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt  <= r_cnt - C_CW'(1);
                        r_done <= (r_cnt == C_CW'(1));
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf [3];
    logic [2:0]       w_inc;

    assign w_inc[0] = w_lw_stall && !hz.PCSrcE && !w_mc_stall;
    assign w_inc[1] = hz.PCSrcE && !w_mc_stall;
    assign w_inc[2] = w_mc_stall;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < 3; k++) begin
                r_perf[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_inc[k] && (r_perf[k] != {CNT_W{1'b1}})) begin
                    r_perf[k] <= r_perf[k] + CNT_W'(1);
                end
            end
        end
    end

    assign hz.LuStallCnt = r_perf[0];
    assign hz.FlushCnt   = r_perf[1];
    assign hz.McStallCnt = r_perf[2];
`else
    assign hz.LuStallCnt = {CNT_W{1'b0}};
    assign hz.FlushCnt   = {CNT_W{1'b0}};
    assign hz.McStallCnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl (MC_LAT=4/CNT_W=16 and MC_LAT=2/CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;
    localparam int NS   = 2;
    localparam int LAT1 = 4;
    localparam int LAT2 = 2;
    localparam int CW1  = 16;
    localparam int CW2  = 4;
    localparam int SAT1 = (1 << CW1) - 1;
    localparam int SAT2 = (1 << CW2) - 1;

    logic CLK;
    logic RESET;

    hazard_ctrl_if #(.NUM_SRC(NS), .CNT_W(CW1)) hz1 ();
    hazard_ctrl_if #(.NUM_SRC(NS), .CNT_W(CW2)) hz2 ();

    hazard_ctrl #(.NUM_SRC(NS), .MC_LAT(LAT1), .CNT_W(CW1)) dut1 (
        .CLK(CLK), .RESET(RESET), .hz(hz1.slave));
    hazard_ctrl #(.NUM_SRC(NS), .MC_LAT(LAT2), .CNT_W(CW2)) dut2 (
        .CLK(CLK), .RESET(RESET), .hz(hz2.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: occupancy position of the op in execute (0 = none, 1..LAT1).
    int m_pos, m_lu, m_fl, m_mc;

    typedef struct {
        logic [9:0] rsd;
        logic [9:0] rse;
        logic [4:0] rde, rdm, rdw;
        logic       rwe, rwm, rww, load, pc;
        logic [3:0] fwd;
        logic [3:0] ctl;   // {StallF, StallD, FlushD, FlushE}
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs != 0 && rs == hz1.RdM && hz1.RegWriteM) return 2'b10;
        if (rs != 0 && rs == hz1.RdW && hz1.RegWriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_lw();
        bit hit = 1'b0;
        for (int i = 0; i < NS; i++) if (hz1.RsD[5*i +: 5] == hz1.RdE) hit = 1'b1;
        return hz1.LoadE && hz1.RegWriteE && hz1.RdE != 0 && hit;
    endfunction

    function automatic int ref_cur();
        return (m_pos == 0 && hz1.McStartE) ? 1 : m_pos;
    endfunction

    function automatic logic [5:0] ref_ctl();
        int p = ref_cur();
        if (p >= 1 && p < LAT1) return 6'b111001;
        if (hz1.PCSrcE)         return 6'b000110;
        if (ref_lw())           return 6'b110010;
        return 6'b000000;
    endfunction

    function automatic logic [5:0] act_ctl1();
        return {hz1.StallF, hz1.StallD, hz1.StallE, hz1.FlushD, hz1.FlushE, hz1.FlushM};
    endfunction

    function automatic logic [5:0] act_ctl2();
        return {hz2.StallF, hz2.StallD, hz2.StallE, hz2.FlushD, hz2.FlushE, hz2.FlushM};
    endfunction

    task automatic check_model(input string tag);
        for (int i = 0; i < NS; i++)
            chk({tag, " fwd"}, 32'(hz1.ForwardE[2*i +: 2]), 32'(ref_fwd(hz1.RsE[5*i +: 5])));
        chk({tag, " ctl"}, 32'(act_ctl1()), 32'(ref_ctl()));
        chk({tag, " done"}, 32'(hz1.McDoneE), 32'(m_pos == LAT1));
        chk({tag, " lucnt"}, 32'(hz1.LuStallCnt), 32'(exp_cnt(m_lu)));
        chk({tag, " flcnt"}, 32'(hz1.FlushCnt), 32'(exp_cnt(m_fl)));
        chk({tag, " mccnt"}, 32'(hz1.McStallCnt), 32'(exp_cnt(m_mc)));
    endtask

    task automatic model_edge();
        int  p  = ref_cur();
        bit  mc = (p >= 1 && p < LAT1);
        if (mc && m_mc < SAT1) m_mc++;
        if (!mc && hz1.PCSrcE && m_fl < SAT1) m_fl++;
        if (!mc && !hz1.PCSrcE && ref_lw() && m_lu < SAT1) m_lu++;
        m_pos = (p == 0 || p == LAT1) ? 0 : p + 1;
    endtask

    task automatic tick(input string tag);
        @(negedge CLK);
        check_model(tag);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic zero_in();
        hz1.RsD = '0; hz1.RsE = '0; hz1.RdE = '0; hz1.RdM = '0; hz1.RdW = '0;
        hz1.RegWriteE = 0; hz1.RegWriteM = 0; hz1.RegWriteW = 0;
        hz1.LoadE = 0; hz1.McStartE = 0; hz1.PCSrcE = 0;
        hz2.RsD = '0; hz2.RsE = '0; hz2.RdE = '0; hz2.RdM = '0; hz2.RdW = '0;
        hz2.RegWriteE = 0; hz2.RegWriteM = 0; hz2.RegWriteW = 0;
        hz2.LoadE = 0; hz2.McStartE = 0; hz2.PCSrcE = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        zero_in();
        #1;
        chk("rst ctl", 32'(act_ctl1()), 32'd0);
        chk("rst done", 32'(hz1.McDoneE), 32'd0);
        chk("rst cnt", 32'(hz1.LuStallCnt | hz1.FlushCnt | hz1.McStallCnt), 32'd0);
        chk("rst cnt2", 32'(hz2.McStallCnt), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        m_pos = 0; m_lu = 0; m_fl = 0; m_mc = 0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int st;
        int pos;
        RESET = 1'b1;
        zero_in();
        m_pos = 0; m_lu = 0; m_fl = 0; m_mc = 0;
        do_reset();

        //            rsd            rse            rde   rdm   rdw  rwe rwm rww ld pc  fwd      ctl
        tbl[0] = '{{5'd0, 5'd0}, {5'd5, 5'd5}, 5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 4'b1010, 4'b0000};
        tbl[1] = '{{5'd0, 5'd0}, {5'd5, 5'd5}, 5'd0, 5'd5, 5'd5, 0, 0, 1, 0, 0, 4'b0101, 4'b0000};
        tbl[2] = '{{5'd0, 5'd0}, {5'd0, 5'd0}, 5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 4'b0000, 4'b0000};
        tbl[3] = '{{5'd0, 5'd0}, {5'd3, 5'd9}, 5'd0, 5'd3, 5'd9, 0, 1, 1, 0, 0, 4'b1001, 4'b0000};
        tbl[4] = '{{5'd7, 5'd2}, {5'd0, 5'd0}, 5'd7, 5'd0, 5'd0, 1, 0, 0, 1, 0, 4'b0000, 4'b1101};
        tbl[5] = '{{5'd0, 5'd2}, {5'd0, 5'd0}, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 0, 4'b0000, 4'b0000};
        tbl[6] = '{{5'd7, 5'd2}, {5'd0, 5'd0}, 5'd7, 5'd0, 5'd0, 1, 0, 0, 1, 1, 4'b0000, 4'b0011};
        tbl[7] = '{{5'd1, 5'd2}, {5'd0, 5'd0}, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0, 1, 4'b0000, 4'b0011};
        tbl[8] = '{{5'd7, 5'd2}, {5'd0, 5'd0}, 5'd7, 5'd0, 5'd0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000};
        tbl[9] = '{{5'd1, 5'd7}, {5'd0, 5'd0}, 5'd7, 5'd0, 5'd0, 1, 0, 0, 1, 0, 4'b0000, 4'b1101};

        for (int r = 0; r < 10; r++) begin
            hz1.RsD = tbl[r].rsd; hz1.RsE = tbl[r].rse;
            hz1.RdE = tbl[r].rde; hz1.RdM = tbl[r].rdm; hz1.RdW = tbl[r].rdw;
            hz1.RegWriteE = tbl[r].rwe; hz1.RegWriteM = tbl[r].rwm; hz1.RegWriteW = tbl[r].rww;
            hz1.LoadE = tbl[r].load; hz1.PCSrcE = tbl[r].pc;
            @(negedge CLK);
            chk($sformatf("vec%0d fwd", r), 32'(hz1.ForwardE), 32'(tbl[r].fwd));
            chk($sformatf("vec%0d ctl", r), 32'({hz1.StallF, hz1.StallD, hz1.FlushD, hz1.FlushE}),
                32'(tbl[r].ctl));
            check_model($sformatf("vec%0d", r));
            @(posedge CLK);
            model_edge();
            #1;
        end
        zero_in();
        tick("post-vec");

        // Two back-to-back multicycle ops with McStartE held throughout.
        do_reset();
        hz1.McStartE = 1'b1;
        st = 0;
        for (int c = 1; c <= 2 * LAT1; c++) begin
            pos = ((c - 1) % LAT1) + 1;
            @(negedge CLK);
            chk($sformatf("mc c%0d ctl", c), 32'(act_ctl1()), (pos < LAT1) ? 32'h39 : 32'h0);
            chk($sformatf("mc c%0d done", c), 32'(hz1.McDoneE), 32'(pos == LAT1));
            chk($sformatf("mc c%0d cnt", c), 32'(hz1.McStallCnt), 32'(exp_cnt(st)));
            @(posedge CLK);
            model_edge();
            #1;
            if (pos < LAT1) st++;
        end
        hz1.McStartE = 1'b0;
        tick("mc end");

        // MC_LAT=2 stream on the narrow-counter instance: saturation at 15.
        do_reset();
        hz2.McStartE = 1'b1;
        st = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            chk($sformatf("mc2 c%0d ctl", c), 32'(act_ctl2()), (c % 2 == 1) ? 32'h39 : 32'h0);
            chk($sformatf("mc2 c%0d done", c), 32'(hz2.McDoneE), 32'(c % 2 == 0));
            chk($sformatf("mc2 c%0d cnt", c), 32'(hz2.McStallCnt),
                32'(exp_cnt((st > SAT2) ? SAT2 : st)));
            @(posedge CLK);
            #1;
            if (c % 2 == 1) st++;
        end
        hz2.McStartE = 1'b0;
        @(negedge CLK);
        chk("mc2 sat", 32'(hz2.McStallCnt), 32'(exp_cnt(15)));
        chk("mc2 other", 32'(hz2.LuStallCnt | hz2.FlushCnt), 32'd0);
        @(posedge CLK);
        #1;

        // Reset while BUSY with cnt=1: no McDoneE afterwards.
        do_reset();
        hz1.McStartE = 1'b1;
        tick("rmid c1");
        tick("rmid c2");
        @(negedge CLK);
        chk("rmid c3 stall", 32'(hz1.StallE), 32'd1);
        RESET = 1'b0;
        hz1.McStartE = 1'b0;
        #1;
        chk("rmid async ctl", 32'(act_ctl1()), 32'd0);
        chk("rmid async done", 32'(hz1.McDoneE), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        m_pos = 0; m_lu = 0; m_fl = 0; m_mc = 0;
        @(posedge CLK);
        #1;
        for (int c = 0; c < 6; c++) tick($sformatf("rmid post%0d", c));

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            hz1.RsD = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            hz1.RsE = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            hz1.RdE = 5'($urandom_range(0, 7));
            hz1.RdM = 5'($urandom_range(0, 7));
            hz1.RdW = 5'($urandom_range(0, 7));
            hz1.RegWriteE = 1'($urandom_range(0, 1));
            hz1.RegWriteM = 1'($urandom_range(0, 1));
            hz1.RegWriteW = 1'($urandom_range(0, 1));
            hz1.LoadE     = 1'($urandom_range(0, 1));
            hz1.McStartE  = ($urandom_range(0, 3) == 0);
            hz1.PCSrcE    = ($urandom_range(0, 4) == 0);
            tick($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and pipeline-control unit for the five-stage pipelined MCU. It generates per-source forwarding selects, load-use stalls, and branch/jump flushes for the fetch, decode, execute, memory and writeback stages. It also adds a variable-latency execute path: a fixed-latency multicycle unit (MUL/DIV) that holds the execute stage via a small state machine. It sits beside the stage modules at the top level and drives their stall/flush/forward inputs.

## Interface
- NUM_SRC, 2: register source operands per instruction (1..3).
- MC_LAT, 4: cycles a multicycle op occupies execute (2..16).
- CNT_W, 16: width of each performance counter.
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RsD  in  5*NUM_SRC  decode-stage source registers; source i is at [5i+4:5i].
- RsE  in  5*NUM_SRC  execute-stage source registers.
- RdE, RdM, RdW  in  5 each  destination register in execute, memory and writeback.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register write enables in execute, memory and writeback.
- LoadE  in  1  execute instruction is a load (ResultSrcE selects memory).
- McStartE  in  1  execute instruction is a multicycle op.
- PCSrcE  in  1  taken branch or jump in execute.
- ForwardE  out  2*NUM_SRC  per-source select: 00 register file, 10 ALUResultM, 01 ResultW.
- StallF, StallD, StallE  out  1 each  hold the stage register.
- FlushD, FlushE, FlushM  out  1 each  bubble the stage register.
- McDoneE  out  1  multicycle result valid this cycle.
- LuStallCnt, FlushCnt, McStallCnt  out  CNT_W each  performance counters.

## Operation
- **Forwarding (combinational), per source i:**
  - 10 if RsE[i]!=0, RsE[i]==RdM and RegWriteM.
  - Otherwise 01 if RsE[i]!=0, RsE[i]==RdW and RegWriteW.
  - Otherwise 00.
  - The memory stage wins when both match.
- **Load-use (lwStall):** LoadE & RegWriteE & RdE!=0 & (any RsD[i]==RdE).
- **Multicycle FSM, states IDLE and BUSY, down-counter cnt of width $clog2(MC_LAT):**
  - IDLE with McStartE: mcStall=1, next state BUSY, cnt<=MC_LAT-2.
  - BUSY with cnt!=0: mcStall=1, cnt<=cnt-1.
  - BUSY with cnt==0: McDoneE=1, mcStall=0, next state IDLE.
  - McStartE is ignored in BUSY.
- **Output equations, by priority:**
  - mcStall: StallF=StallD=StallE=1 and FlushM=1. lwStall and PCSrcE are ignored.
  - Otherwise PCSrcE: FlushD=FlushE=1 and StallF=StallD=0. PCSrcE overrides lwStall.
  - Otherwise lwStall: StallF=StallD=1 and FlushE=1.
  - Otherwise all stall and flush outputs are 0.
- StallE and FlushM are asserted only by mcStall.

## Timing
- **Reset:** on RESET low, asynchronously:
  - state=IDLE and cnt=0;
  - McDoneE=0 and all counters 0;
  - all stall and flush outputs 0 (they are combinational, and follow from state=IDLE).
- **Forwarding, lwStall, PCSrcE:** zero-latency combinational outputs, settled before the next CLK edge.
- **Multicycle occupancy:** a multicycle op stays in execute exactly MC_LAT cycles.
  - Stalls are high for the first MC_LAT-1 cycles.
  - McDoneE is high in cycle MC_LAT only.
  - On the next edge the op advances to memory.
- **Back-to-back multicycle ops:** the second enters execute the cycle after McDoneE and starts with no idle gap.
- **RESET low mid-BUSY:** the operation is abandoned and McDoneE is never pulsed.
- **Performance counters:** saturate at 2^CNT_W-1 and never wrap. Each increments one cycle after its qualifying cycle:
  - LuStallCnt: lwStall & !PCSrcE & !mcStall.
  - FlushCnt: PCSrcE & !mcStall.
  - McStallCnt: mcStall.

## Configuration
- **HAZARD_PERF_CNT_EN defined:** the three counters are implemented as above.
- **HAZARD_PERF_CNT_EN undefined:** the counter registers are not built and LuStallCnt, FlushCnt and McStallCnt are driven constant 0. All other behaviour is identical.

## Test plan
- **Forwarding:** NUM_SRC=2, RsE={5,5}, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardE=4'b1010. Then RegWriteM=0 -> 4'b0101. Then RsE={0,0} -> 4'b0000.
- **Load-use:** LoadE=1, RegWriteE=1, RdE=7, RsD[1]=7 -> StallF=StallD=FlushE=1 for one cycle and LuStallCnt becomes 1. Same with RdE=0 -> no stall.
- **Branch priority:** lwStall condition plus PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0, FlushCnt+1, LuStallCnt unchanged.
- **Multicycle latency:** MC_LAT=4, McStartE held while stalled -> stalls and FlushM high for 3 cycles, McDoneE high in cycle 4, McStallCnt=3. A second op immediately after gives the same pattern with no gap. MC_LAT=2 -> 1 stall cycle, then done.
- **Reset mid-operation:** RESET low during BUSY at cnt=1 -> stall outputs 0 immediately, state IDLE, no McDoneE pulse after release.
- **Counter saturation:** with CNT_W=4 and HAZARD_PERF_CNT_EN defined, hold a multicycle stream for 20 stall cycles -> McStallCnt=15. Without the macro all counters read 0.
